// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch PC sequencer: FSM states, redirect
// sources and the per-fetch PC step.
package pc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        REDIR
    } state_e;

    typedef enum logic [2:0] {
        SRC_EXC,
        SRC_RET,
        SRC_JMP,
        SRC_BR,
        SRC_SEQ
    } src_e;

    // Address units covered by one fetch; callers truncate to their PC width.
    function automatic logic [127:0] step(input logic        wide_mode,
                                          input int unsigned instr_bits,
                                          input int unsigned fetch_n);
        logic [127:0] w_one;
        w_one = 128'(instr_bits);
        return wide_mode ? w_one * 128'(fetch_n) : w_one;
    endfunction

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack: a push onto a full stack silently replaces
// the oldest entry, so the newest DEPTH return addresses are always kept.
module return_addr_stack #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 72
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wp;
    logic [CW-1:0]    r_cnt;
    logic [PW-1:0]    w_wp_inc;
    logic [PW-1:0]    w_wp_dec;

    // Write pointer addresses the next free slot; the top sits just below it.
    assign w_wp_inc = (r_wp == PW'(DEPTH - 1)) ? '0 : r_wp + PW'(1);
    assign w_wp_dec = (r_wp == '0) ? PW'(DEPTH - 1) : r_wp - PW'(1);

    assign top   = r_mem[w_wp_dec];
    assign empty = (r_cnt == '0);
    assign full  = (r_cnt == CW'(DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp  <= '0;
            r_cnt <= '0;
        end else if (flush) begin
            r_wp  <= '0;
            r_cnt <= '0;
        end else if (push) begin
            r_wp <= w_wp_inc;
            if (!full) r_cnt <= r_cnt + CW'(1);
        end else if (pop && !empty) begin
            r_wp  <= w_wp_dec;
            r_cnt <= r_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) r_mem[r_wp] <= din;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: prioritised redirects (exc > ret > jump > branch),
// sequential advance on accepted fetches, and call/return through the RAS.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int              PC_W       = 72,
    parameter int              INSTR_BITS = 60,
    parameter int              FETCH_N    = 2,
    parameter int              RAS_DEPTH  = 8,
    parameter logic [PC_W-1:0] RESET_PC   = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wide_mode,
    input  logic            exc_en,
    input  logic [PC_W-1:0] exc_addr,
    input  logic            jump_en,
    input  logic [PC_W-1:0] jump_addr,
    input  logic            call_en,
    input  logic            ret_en,
    input  logic            branch_en,
    input  logic [PC_W-1:0] branch_addr,
    input  logic            fetch_ready,
    output logic            fetch_valid,
    output logic [PC_W-1:0] pc,
    output logic            ras_ovf,
    output logic            ras_unf
);

    state_e          r_state;
    state_e          w_state_nxt;
    src_e            w_src;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_nxt;
    logic [PC_W-1:0] w_step;
    logic [PC_W-1:0] w_seq_pc;
    logic            w_active;
    logic            w_redir;
    logic            w_push;
    logic            w_pop;
    logic            w_flush;
    logic            w_ovf_nxt;
    logic            w_unf_nxt;
    logic            r_ovf;
    logic            r_unf;
    logic [PC_W-1:0] w_ras_top;
    logic            w_ras_empty;
    logic            w_ras_full;

    assign w_step   = PC_W'(step(wide_mode, INSTR_BITS, FETCH_N));
    assign w_seq_pc = r_pc + w_step;

    always_comb begin
        w_src = SRC_SEQ;
        if (exc_en)         w_src = SRC_EXC;
        else if (ret_en)    w_src = SRC_RET;
        else if (jump_en)   w_src = SRC_JMP;
        else if (branch_en) w_src = SRC_BR;
    end

    // Redirect requests are only meaningful once the sequencer has left IDLE.
    assign w_active = (r_state != IDLE);
    assign w_redir  = w_active && (w_src != SRC_SEQ);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_flush     = 1'b0;
        w_ovf_nxt   = 1'b0;
        w_unf_nxt   = 1'b0;
        case (r_state)
            IDLE:       w_state_nxt = RUN;
            RUN, REDIR: w_state_nxt = w_redir ? REDIR : RUN;
            default:    w_state_nxt = IDLE;
        endcase
        if (w_active) begin
            case (w_src)
                SRC_EXC: begin
                    w_pc_nxt = exc_addr;
                    w_flush  = 1'b1;
                end
                SRC_RET: begin
                    if (!w_ras_empty) begin
                        w_pop    = 1'b1;
                        w_pc_nxt = w_ras_top;
                    end else begin
                        w_pc_nxt  = jump_addr;
                        w_unf_nxt = 1'b1;
                    end
                end
                SRC_JMP: begin
                    w_pc_nxt = jump_addr;
                    if (call_en) begin
                        w_push    = 1'b1;
                        w_ovf_nxt = w_ras_full;
                    end
                end
                SRC_BR:  w_pc_nxt = branch_addr;
                default: begin
                    if (r_state == RUN && fetch_ready) w_pc_nxt = w_seq_pc;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc  <= RESET_PC;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_pc  <= w_pc_nxt;
            r_ovf <= w_ovf_nxt;
            r_unf <= w_unf_nxt;
        end
    end

    return_addr_stack #(
        .DEPTH(RAS_DEPTH),
        .WIDTH(PC_W)
    ) u_ras (
        .clk  (clk),
        .rst_n(reset),
        .push (w_push),
        .pop  (w_pop),
        .flush(w_flush),
        .din  (w_seq_pc),
        .top  (w_ras_top),
        .empty(w_ras_empty),
        .full (w_ras_full)
    );

    assign fetch_valid = (r_state == RUN);
    assign pc          = r_pc;
    assign ras_ovf     = r_ovf;
    assign ras_unf     = r_unf;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the fetch front end. It holds the bit-addressed fetch PC and advances it by one or FETCH_N instructions per accepted fetch. It applies exception, return, jump and branch redirects in a fixed priority, and keeps a return-address stack (RAS) for call/return. It sits between the branch/exception logic and the instruction fetch stage, and talks to fetch over a valid/ready handshake.

## Interface
- PC_W, 72: PC and target address width, in bits of address.
- INSTR_BITS, 60: instruction size in address units.
- FETCH_N, 2: instructions per fetch group in wide mode.
- RAS_DEPTH, 8: return-address stack entries, ≥2.
- RESET_PC, 0: PC value loaded on reset.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- wide_mode  in  1  1: step = FETCH_N·INSTR_BITS; 0: step = INSTR_BITS.
- exc_en / exc_addr  in  1 / PC_W  exception redirect.
- jump_en / jump_addr  in  1 / PC_W  jump redirect.
- call_en  in  1  qualifies jump_en as a call.
- ret_en  in  1  return; target is the RAS top.
- branch_en / branch_addr  in  1 / PC_W  taken-branch redirect.
- fetch_ready  in  1  fetch stage accepts pc this cycle.
- fetch_valid  out  1  pc is a valid fetch address.
- pc  out  PC_W  current fetch address.
- ras_ovf  out  1  one-cycle pulse: push onto a full RAS.
- ras_unf  out  1  one-cycle pulse: ret_en with an empty RAS.

## Operation
- States:
  - IDLE: entered on reset; fetch_valid=0.
  - RUN: fetch_valid=1.
  - REDIR: fetch_valid=0.
- State transitions:
  - IDLE→RUN on the first clock edge after reset release.
  - RUN→REDIR on any redirect.
  - REDIR→RUN after one cycle, unless a new redirect arrives, which keeps the state in REDIR.
- Redirect priority, highest first: exc_en > ret_en > jump_en > branch_en > sequential.
- Only the winning redirect takes effect. Losing requests are dropped, including their RAS side effects.
- Redirects are honoured in RUN and REDIR regardless of fetch_ready. Redirects in IDLE are ignored.
- Sequential advance: pc ← pc + step, only in RUN when fetch_valid && fetch_ready. Otherwise pc holds.
- Arithmetic: all PC arithmetic is modulo 2^PC_W, so pc wraps silently. step is computed at PC_W width.
- Call (jump wins with call_en=1):
  - Push pc + step (using the current wide_mode) onto the RAS.
  - pc ← jump_addr.
  - call_en without jump_en is ignored.
- Return (ret wins):
  - RAS non-empty: pop, and pc ← popped value.
  - RAS empty: pc ← jump_addr, and ras_unf pulses.
- RAS full on push: the oldest entry is overwritten (circular), the count stays RAS_DEPTH, and ras_ovf pulses.
- Exception: pc ← exc_addr and the RAS is flushed (count 0).

## Timing
- Reset (asynchronous assert):
  - pc=RESET_PC, fetch_valid=0, ras_ovf=0, ras_unf=0, RAS count=0, state=IDLE.
- Release of reset is sampled synchronously. fetch_valid rises at the first clock edge after release.
- Redirect latency:
  - Request at edge N → pc = target after edge N.
  - fetch_valid is 0 for that cycle and returns to 1 after edge N+1.
- ras_ovf and ras_unf are registered and assert in the cycle after the causing edge, for exactly one cycle.
- A push and a pop never occur in the same cycle, because call and return are mutually exclusive by priority.
- Reset asserted mid-REDIR or mid-stall: immediate return to the full reset state, and RAS contents are discarded.

## Structure
- Package pc_pkg holds:
  - state enum {IDLE, RUN, REDIR};
  - redirect-source enum {SRC_EXC, SRC_RET, SRC_JMP, SRC_BR, SRC_SEQ};
  - a step(wide_mode) function.
- Sub-module return_addr_stack holds the circular RAS.
  - Parameters: depth and width.
  - Ports: push, pop, flush, din, top, empty, full.
- The top level contains the FSM, the priority mux and the PC register.

## Test plan
- Reset behaviour: deassert reset, fetch_ready=1, wide_mode=1 → pc sequence 0, 120, 240. fetch_valid first high one cycle after release.
- Stall: fetch_ready=0 for 3 cycles at pc=240 → pc holds at 240. Then ready=1 → pc=360. With wide_mode=0 the next step is 420.
- Simultaneous redirects: exc_en, jump_en and branch_en in the same cycle with exc_addr=0x500 → pc=0x500, fetch_valid low one cycle, RAS flushed.
- Call/return: call at pc=0x100, wide mode, jump_addr=0x800 → pc=0x800. Then ret_en → pc=0x178 (0x100 + 120).
- RAS limits:
  - RAS_DEPTH+1 nested calls → ras_ovf pulses once, then the deepest RAS_DEPTH returns come back in LIFO order.
  - A further ret → pc=jump_addr and ras_unf pulses.
- Wrap and reset: pc=2^PC_W−60, wide_mode=0 → pc=0. Assert reset during REDIR → pc=RESET_PC and fetch_valid=0 immediately, without waiting for a clock edge.
